// File: rtl/dct_mul_pkg.sv
// dct_mul_pkg: default operand/product widths shared by the DCT multiplier
// arbiter and its users, plus the response record {id, data}.
package dct_mul_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);
   localparam int A_W         = 16;
   localparam int B_W         = 15;
   localparam int P_W         = 29;

   // One registered product, tagged with the requester that owns it.
   typedef struct packed {
      logic [ID_W_DEF-1:0] id;
      logic [P_W-1:0]      data;
   } mul_rsp_t;

endpackage

// File: rtl/dct_mul_16s_15ns_29_1_1.sv
// dct_mul_16s_15ns_29_1_1: combinational signed x unsigned multiplier.
// din0 is signed, din1 is unsigned; dout keeps the low dout_WIDTH bits.
module dct_mul_16s_15ns_29_1_1 #(
   parameter int din0_WIDTH = 16,
   parameter int din1_WIDTH = 15,
   parameter int dout_WIDTH = 29
) (
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic [dout_WIDTH-1:0] dout
);

   localparam int FULL_W = din0_WIDTH + din1_WIDTH + 1;

   logic signed [FULL_W-1:0] full;

   // Zero-extend din1 so it is treated as a non-negative signed value.
   assign full = FULL_W'($signed(din0)) * FULL_W'($signed({1'b0, din1}));
   assign dout = full[dout_WIDTH-1:0];

endmodule

// File: rtl/dct_mul_rr_pick.sv
// dct_mul_rr_pick: combinational cyclic priority picker. Searches req
// starting at (last+1) mod NUM_REQ and returns the first set bit.
module dct_mul_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   // Walk the ring in priority order; the first valid requester wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i == ((int'(last) + k) % NUM_REQ))) begin
               any      = 1'b1;
               idx      = ID_W'(i);
               grant[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/dct_mul_arbiter.sv
// dct_mul_arbiter: round-robin sharing of one signed x unsigned multiplier
// among NUM_REQ requesters, with a single-entry tagged output register.
// Optional DCT_MUL_ARB_STATS_EN adds grant and stall counters.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A requester is ready only when it is granted and the output stage
// can accept (empty, or being drained this cycle); ready never depends on
// the operand values.
module dct_mul_arbiter #(
   parameter int NUM_REQ = dct_mul_pkg::NUM_REQ_DEF,
   parameter int A_W     = dct_mul_pkg::A_W,
   parameter int B_W     = dct_mul_pkg::B_W,
   parameter int P_W     = dct_mul_pkg::P_W,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*A_W-1:0] req_a,
   input  logic [NUM_REQ*B_W-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [P_W-1:0]         rsp_data
`ifdef DCT_MUL_ARB_STATS_EN
   ,
   output logic [31:0]            stat_grant_cnt,
   output logic [31:0]            stat_stall_cnt
`endif
);

   logic               accept;
   logic               hs;
   logic [NUM_REQ-1:0] pick_grant;
   logic [ID_W-1:0]    pick_idx;
   logic               pick_any;
   logic [ID_W-1:0]    last;
   logic [A_W-1:0]     a_sel;
   logic [B_W-1:0]     b_sel;
   logic [P_W-1:0]     prod;

   // The output stage can take a new product when empty or draining now.
   assign accept    = !rsp_valid || rsp_ready;
   // Reset is folded in so nothing looks granted while held in reset.
   assign req_ready = (ap_rst_n && accept) ? pick_grant : '0;
   assign hs        = ap_rst_n && accept && pick_any;

   dct_mul_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req   (req_valid),
      .last  (last),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Route the picked requester's operands to the shared multiplier.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == ID_W'(i)) begin
            a_sel = req_a[i*A_W +: A_W];
            b_sel = req_b[i*B_W +: B_W];
         end
      end
   end

   dct_mul_16s_15ns_29_1_1 #(
      .din0_WIDTH (A_W),
      .din1_WIDTH (B_W),
      .dout_WIDTH (P_W)
   ) u_mul (
      .din0 (a_sel),
      .din1 (b_sel),
      .dout (prod)
   );

   // Round-robin pointer moves only on an actual transfer.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         last <= ID_W'(NUM_REQ - 1);
      end else if (hs) begin
         last <= pick_idx;
      end
   end

   // Output stage: load on transfer, clear when drained, hold otherwise.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else if (hs) begin
         rsp_valid <= 1'b1;
         rsp_id    <= pick_idx;
         rsp_data  <= prod;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

`ifdef DCT_MUL_ARB_STATS_EN
   // Free-running wrap-around counters of transfers and output stalls.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         stat_grant_cnt <= '0;
         stat_stall_cnt <= '0;
      end else begin
         if (hs) begin
            stat_grant_cnt <= stat_grant_cnt + 32'd1;
         end
         if (rsp_valid && !rsp_ready) begin
            stat_stall_cnt <= stat_stall_cnt + 32'd1;
         end
      end
   end
`else
   // Statistics disabled: no counters and no extra ports.
`endif

endmodule

// File: tb/tb_dct_mul_arbiter.sv
// tb_dct_mul_arbiter: directed scoreboard bench for dct_mul_arbiter.
module tb_dct_mul_arbiter;

   localparam int NUM_REQ = 4;
   localparam int A_W     = 16;
   localparam int B_W     = 15;
   localparam int P_W     = 29;
   localparam int ID_W    = 2;
   localparam int EW      = $bits(dct_mul_pkg::mul_rsp_t);

   logic                   ap_clk = 1'b0;
   logic                   ap_rst_n;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*A_W-1:0] req_a;
   logic [NUM_REQ*B_W-1:0] req_b;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   logic [P_W-1:0]         rsp_data;
`ifdef DCT_MUL_ARB_STATS_EN
   logic [31:0]            stat_grant_cnt;
   logic [31:0]            stat_stall_cnt;
   logic [31:0]            stall0;
`endif

   logic signed [A_W-1:0] a_v [NUM_REQ];
   logic        [B_W-1:0] b_v [NUM_REQ];
   logic        [P_W-1:0] p_tab [NUM_REQ];

   logic [EW-1:0] exp_q[$];
   int n_cmp  = 0;
   int n_fail = 0;

   assign req_a = {a_v[3], a_v[2], a_v[1], a_v[0]};
   assign req_b = {b_v[3], b_v[2], b_v[1], b_v[0]};

   dct_mul_arbiter #(
      .NUM_REQ (NUM_REQ),
      .A_W     (A_W),
      .B_W     (B_W),
      .P_W     (P_W),
      .ID_W    (ID_W)
   ) dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
`ifdef DCT_MUL_ARB_STATS_EN
      ,
      .stat_grant_cnt (stat_grant_cnt),
      .stat_stall_cnt (stat_stall_cnt)
`endif
   );

   // ---------------- clock ----------------
   always #5 ap_clk = ~ap_clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int id, input logic [P_W-1:0] data);
      dct_mul_pkg::mul_rsp_t e;
      e.id   = ID_W'(id);
      e.data = data;
      exp_q.push_back(e);
   endtask

   // One cycle: check req_ready mid-cycle, then cross the rising edge.
   task automatic step(input logic [NUM_REQ-1:0] exp_ready);
      @(negedge ap_clk);
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      @(posedge ap_clk);
      #1;
   endtask

   task automatic check_idle();
      @(negedge ap_clk);
      check("rsp_valid_idle", 64'(rsp_valid), 64'd0);
      @(posedge ap_clk);
      #1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge ap_clk) begin
      if (ap_rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rsp: got id %0d data %0h, expected nothing", rsp_id, rsp_data);
         end else begin
            dct_mul_pkg::mul_rsp_t e;
            e = exp_q.pop_front();
            check("rsp_id", 64'(rsp_id), 64'(e.id));
            check("rsp_data", 64'(rsp_data), 64'(e.data));
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      ap_rst_n  = 1'b0;
      rsp_ready = 1'b0;
      a_v[0] = 16'sd5;   b_v[0] = 15'd3;     p_tab[0] = 29'(15);
      a_v[1] = -16'sd7;  b_v[1] = 15'd2;     p_tab[1] = 29'(-14);
      a_v[2] = 16'sd100; b_v[2] = 15'd10;    p_tab[2] = 29'(1000);
      a_v[3] = -16'sd1;  b_v[3] = 15'd30000; p_tab[3] = 29'(-30000);
      req_valid = 4'hF;

      // Reset values, with every requester asserting valid.
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_id", 64'(rsp_id), 64'd0);
      check("reset_rsp_data", 64'(rsp_data), 64'd0);
      check("reset_req_ready", 64'(req_ready), 64'd0);
      @(posedge ap_clk);
      #1;
      ap_rst_n  = 1'b1;
      rsp_ready = 1'b1;

      // Full contention: 0,1,2,3,0,1,2,3 with a product every cycle.
      for (int k = 0; k < 8; k++) begin
         push_exp(k % 4, p_tab[k % 4]);
         step(4'(1 << (k % 4)));
      end

      // Backpressure for 5 cycles: output holds requester 3's product.
      rsp_ready = 1'b0;
`ifdef DCT_MUL_ARB_STATS_EN
      stall0 = stat_stall_cnt;
`endif
      for (int k = 0; k < 5; k++) begin
         @(negedge ap_clk);
         check("bp_req_ready", 64'(req_ready), 64'd0);
         check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
         check("bp_rsp_id", 64'(rsp_id), 64'd3);
         check("bp_rsp_data", 64'(rsp_data), 64'(p_tab[3]));
         @(posedge ap_clk);
         #1;
      end
`ifdef DCT_MUL_ARB_STATS_EN
      check("stall_cnt_plus5", 64'(stat_stall_cnt - stall0), 64'd5);
`endif
      // Release: round-robin continues at requester 0.
      rsp_ready = 1'b1;
      push_exp(0, p_tab[0]);
      step(4'b0001);
      push_exp(1, p_tab[1]);
      step(4'b0010);
      req_valid = 4'b0000;
      step(4'b0000);
      check_idle();

      // Single requester 2: -3 * 1000.
      a_v[2] = -16'sd3;
      b_v[2] = 15'd1000;
      req_valid = 4'b0100;
      push_exp(2, 29'(-3000));
      step(4'b0100);
      req_valid = 4'b0000;
      @(negedge ap_clk);
      check("single_rsp_valid", 64'(rsp_valid), 64'd1);
      @(posedge ap_clk);
      #1;
      check_idle();

      // Extreme operands (last=2, so 0 wins before 1).
      a_v[0] = -16'sd32768; b_v[0] = 15'd8191;
      a_v[1] = 16'sd32767;  b_v[1] = 15'd0;
      req_valid = 4'b0011;
      push_exp(0, 29'(-268402688));
      step(4'b0001);
      push_exp(1, 29'd0);
      step(4'b0010);
      req_valid = 4'b0000;
      step(4'b0000);
      check_idle();

      // Sparse: requesters 1 and 3 with last=1 -> 3,1,3,1.
      req_valid = 4'b1010;
      push_exp(3, p_tab[3]);
      step(4'b1000);
      push_exp(1, 29'd0);
      step(4'b0010);
      push_exp(3, p_tab[3]);
      step(4'b1000);
      push_exp(1, 29'd0);
      step(4'b0010);
      req_valid = 4'b0000;
      step(4'b0000);
      check_idle();

      // Reset mid-stream: leave last=0 with a stalled product, then reset.
      a_v[0] = 16'sd5;  b_v[0] = 15'd3;
      a_v[1] = -16'sd7; b_v[1] = 15'd2;
      a_v[2] = 16'sd100; b_v[2] = 15'd10;
      req_valid = 4'b0001;
      push_exp(0, p_tab[0]);
      step(4'b0001);
      rsp_ready = 1'b0;
      req_valid = 4'b0000;
      @(negedge ap_clk);
      check("pre_reset_rsp_valid", 64'(rsp_valid), 64'd1);
      ap_rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("midrst_rsp_id", 64'(rsp_id), 64'd0);
      check("midrst_rsp_data", 64'(rsp_data), 64'd0);
      void'(exp_q.pop_back());
`ifdef DCT_MUL_ARB_STATS_EN
      check("midrst_stall_cnt", 64'(stat_stall_cnt), 64'd0);
`endif
      @(posedge ap_clk);
      #1;
      ap_rst_n  = 1'b1;
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      push_exp(0, p_tab[0]);
      step(4'b0001);
      req_valid = 4'b0000;
      step(4'b0000);
      check_idle();

      check("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dct_mul_arbiter.md
# dct_mul_arbiter

Round-robin scheduler that shares one combinational signed×unsigned multiplier (A_W-bit signed × B_W-bit unsigned → P_W-bit signed) among NUM_REQ requesters in the DCT datapath. Each requester presents operands on a valid/ready channel. The block grants one requester per cycle and registers the product into a single-entry output stage tagged with the requester index. The downstream consumer drains that stage with valid/ready. It sits between the row/column DCT butterfly stages and the one shared multiplier instance.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; 2..8.
- A_W, 16: signed operand width.
- B_W, 15: unsigned operand width.
- P_W, 29: product width.
- ID_W, $clog2(NUM_REQ): response tag width.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*A_W  signed operands; requester i at [i*A_W +: A_W].
- req_b  in  NUM_REQ*B_W  unsigned operands; requester i at [i*B_W +: B_W].
- rsp_valid  out  1  product valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_data  out  P_W  signed product.

## Operation
- accept = !rsp_valid || rsp_ready. This is a combinational function of state and rsp_ready.
- Arbitration: when accept=1, grant goes to the first i with req_valid[i]=1, searching cyclically from (last+1) mod NUM_REQ.
- req_ready[i] = accept && grant[i]. req_ready has no combinational path from req_a or req_b.
- `last` is a register. It updates to the granted index only on a handshake. On reset `last` = NUM_REQ-1, so requester 0 has first priority.
- On handshake: rsp_data ← low P_W bits of $signed(a)*$signed({1'b0,b}); rsp_id ← granted index; rsp_valid ← 1.
- Output rules:
  - No handshake and rsp_ready=1: rsp_valid ← 0.
  - rsp_valid=1 and rsp_ready=0: rsp_valid, rsp_id and rsp_data hold stable.
- Requesters must keep operands within the range that fits P_W. The block truncates silently and does not flag overflow.
- req_valid may drop without a handshake; the block keeps no per-requester state.
- Reset mid-operation: any pending product is discarded, and `last` returns to NUM_REQ-1.

## Timing
- Latency: product visible on rsp_valid/rsp_data one cycle after the req handshake.
- Throughput: one product per cycle while rsp_ready=1.
- With all requesters valid, each is granted once every NUM_REQ accepted cycles.
- Simultaneous rsp handshake and new req handshake in one cycle: the output register reloads and rsp_valid stays 1.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0 while ap_rst_n=0.
- The first grant is possible in the first clock edge after ap_rst_n deasserts.

## Configuration
- DCT_MUL_ARB_STATS_EN defined: adds output ports stat_grant_cnt (32 bits) and stat_stall_cnt (32 bits).
  - stat_grant_cnt increments on every req handshake.
  - stat_stall_cnt increments on every cycle with rsp_valid=1 and rsp_ready=0.
  - Both counters reset to 0 asynchronously and wrap at 2^32.
- Undefined: the counters and their ports are absent, and arbitration behaviour is identical.

## Structure
- Shared package dct_mul_pkg holds the default widths (A_W, B_W, P_W) and a typedef for the response record {id, data}.
- One sub-module: dct_mul_rr_pick, a combinational cyclic priority picker.
  - Inputs: req vector, last.
  - Outputs: one-hot grant, index, any.
- The multiplier is the existing dct_mul_16s_15ns_29_1_1 instance. It is fed from a mux selected by the picker's index.

## Test plan
- Single requester: req 2 sends a=-3, b=1000 with rsp_ready=1. Expected: the next cycle shows rsp_valid=1, rsp_id=2, rsp_data=-3000. rsp_valid drops the cycle after that.
- Full contention: all four requesters held valid with rsp_ready=1. Expected: grant order 0,1,2,3,0,1,… and a product every cycle.
- Backpressure: rsp_ready=0 for 5 cycles while the output is loaded. Expected: req_ready all 0, rsp_* stable, stat_stall_cnt +5. On release, the next grant continues the round-robin order.
- Extreme operands: a=-32768, b=8191. Expected: rsp_data equals the low 29 bits of -268402688. Also a=32767, b=0 gives rsp_data=0.
- Reset mid-stream: ap_rst_n pulses low while rsp_valid=1. Expected: rsp_valid=0 immediately and the stall is not counted. The first grant after reset goes to requester 0 even if `last` was 0 before reset.
- Sparse requests: requesters 1 and 3 valid, last=1. Expected: grant 3, then 1, alternating.
